// File: rtl/hamm_secded_codec.sv
`default_nettype none
// ============================================================================
// Module   : hamm_secded_codec
// Brief    : Two-stage streaming Hamming SECDED encoder/decoder with counters.
// Revision : 1.0
// ============================================================================
module hamm_secded_codec #(
  parameter int DATA_W = 4,
  parameter int CNT_W  = 16,
  localparam int P      = $clog2(DATA_W + $clog2(DATA_W) + 1),
  localparam int CODE_W = DATA_W + P + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic [CODE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [CODE_W-1:0] out_data,
  output logic [1:0]        out_err,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              clear_cnt,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt
);

  localparam logic [1:0] c_ERR_NONE = 2'b00;
  localparam logic [1:0] c_ERR_CORR = 2'b01;
  localparam logic [1:0] c_ERR_DBL  = 2'b10;

  function automatic logic [CODE_W-1:0] f_encode(input logic [DATA_W-1:0] d);
    logic [CODE_W-1:0] c;
    logic              p;
    int                j;
    c = '0;
    j = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        c[i] = d[j];
        j++;
      end
    end
    for (int k = 0; k < P; k++) begin
      p = 1'b0;
      for (int i = 1; i < CODE_W; i++) begin
        if (((i >> k) & 1) == 1) p = p ^ c[i];
      end
      c[1 << k] = p;
    end
    c[0] = ^c[CODE_W-1:1];
    return c;
  endfunction

  function automatic logic [P-1:0] f_syndrome(input logic [CODE_W-1:0] c);
    logic [P-1:0] s;
    s = '0;
    for (int i = 1; i < CODE_W; i++) begin
      if (c[i]) s = s ^ P'(i);
    end
    return s;
  endfunction

  function automatic logic [DATA_W-1:0] f_extract(input logic [CODE_W-1:0] c);
    logic [DATA_W-1:0] d;
    int                j;
    d = '0;
    j = 0;
    for (int i = 1; i < CODE_W; i++) begin
      if ((i & (i - 1)) != 0) begin
        d[j] = c[i];
        j++;
      end
    end
    return d;
  endfunction

  logic              r_rdy_en;
  logic              r_s1_valid;
  logic              r_s1_mode;
  logic              r_s1_q;
  logic [CODE_W-1:0] r_s1_data;
  logic [P-1:0]      r_s1_syn;
  logic              r_s2_valid;
  logic [CODE_W-1:0] r_s2_data;
  logic [1:0]        r_s2_err;
  logic [CNT_W-1:0]  r_corr;
  logic [CNT_W-1:0]  r_uncorr;

  logic              w_s2_adv;
  logic              w_in_ready;
  logic              w_out_fire;
  logic [CODE_W-1:0] w_fixed;
  logic [CODE_W-1:0] w_res_data;
  logic [1:0]        w_res_err;

  assign w_s2_adv   = ~r_s2_valid | out_ready;
  // r_rdy_en keeps in_ready low during reset and until the first edge after it.
  assign w_in_ready = r_rdy_en & (~r_s1_valid | w_s2_adv);
  assign w_out_fire = r_s2_valid & out_ready;

  always_comb begin
    w_fixed    = r_s1_data;
    w_res_err  = c_ERR_NONE;
    w_res_data = '0;
    if (!r_s1_mode) begin
      w_res_data = f_encode(r_s1_data[DATA_W-1:0]);
    end else begin
      if (r_s1_q) begin
        // A syndrome pointing past the codeword can only come from 3+ flips.
        if (int'(r_s1_syn) >= CODE_W) begin
          w_res_err = c_ERR_DBL;
        end else begin
          w_res_err = c_ERR_CORR;
          w_fixed   = r_s1_data ^ (CODE_W'(1) << r_s1_syn);
        end
      end else if (r_s1_syn != '0) begin
        w_res_err = c_ERR_DBL;
      end
      w_res_data = CODE_W'(f_extract(w_fixed));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdy_en   <= 1'b0;
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_q     <= 1'b0;
      r_s1_data  <= '0;
      r_s1_syn   <= '0;
    end else begin
      r_rdy_en <= 1'b1;
      if (w_in_ready) begin
        r_s1_valid <= in_valid;
        if (in_valid) begin
          r_s1_mode <= mode;
          r_s1_data <= in_data;
          r_s1_syn  <= f_syndrome(in_data);
          r_s1_q    <= ^in_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_valid <= 1'b0;
      r_s2_data  <= '0;
      r_s2_err   <= c_ERR_NONE;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_data <= w_res_data;
        r_s2_err  <= w_res_err;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_corr   <= '0;
      r_uncorr <= '0;
    end else if (clear_cnt) begin
      r_corr   <= '0;
      r_uncorr <= '0;
    end else if (w_out_fire) begin
      if (r_s2_err == c_ERR_CORR && r_corr != '1)  r_corr   <= r_corr + CNT_W'(1);
      if (r_s2_err == c_ERR_DBL && r_uncorr != '1) r_uncorr <= r_uncorr + CNT_W'(1);
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_s2_valid;
  assign out_data   = r_s2_data;
  assign out_err    = r_s2_err;
  assign corr_cnt   = r_corr;
  assign uncorr_cnt = r_uncorr;

endmodule
`default_nettype wire
